// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state encoding and default operand width
package serial_add_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle of the bit-serial adder (ovf present with SERIAL_ADD_OVF_EN)
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// fa_bit: single 1-bit full-adder cell shared by the serial controller
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic Cin,
  output logic Cout,
  output logic Sum
);
  assign Sum  = x ^ y ^ Cin;
  assign Cout = (x & y) | (Cin & (x ^ y));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, LSB first, one cell step per clock (optional ovf via SERIAL_ADD_OVF_EN)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;
  fa_bit u_fa (
    .x   (r_a_sr[0]),
    .y   (r_b_sr[0]),
    .Cin (r_carry),
    .Cout(w_cout),
    .Sum (w_sum)
  );
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // A start on the DONE exit edge is taken so a new operation can begin every WIDTH+1 cycles
  assign w_accept = bus.start && (r_state == IDLE || r_state == DONE);
  // Controller FSM: capture operands, step the cell LSB first, pulse done after the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_state <= RUN;
      r_a_sr  <= bus.a;
      r_b_sr  <= bus.b;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= bus.cin;
      r_cout  <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_sum   <= {w_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_cout;
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_cout  <= w_cout;
            r_ovf   <= r_carry ^ w_cout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = r_ovf;
`else
  logic w_unused;
  assign w_unused = r_ovf;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADD_OVF_EN
    check(tag, {31'd0, bus.ovf}, {31'd0, exp});
`endif
  endtask
  // Called just after the accepting edge E0; watches ncyc cycles, scrambling inputs on the way
  task automatic watch(input string tag, input logic [7:0] es, input logic ec, input logic eo,
                       input int hold, input int ncyc);
    int nbusy;
    int ndone;
    int dk;
    nbusy = 0;
    ndone = 0;
    dk = -1;
    for (int k = 0; k < ncyc; k++) begin
      bus.start = (k < hold);
      if (k == 2) begin
        bus.a = ~bus.a;
        bus.b = 8'h5A;
        bus.cin = ~bus.cin;
      end
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        dk = k;
        check({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        check_ovf({tag, "_ovf"}, eo);
      end
      tick();
    end
    if (ncyc >= 12) begin
      check({tag, "_busy_cycles"}, nbusy, 9);
      check({tag, "_done_count"}, ndone, 1);
      check({tag, "_done_cycle"}, dk, 8);
      check({tag, "_sum_hold"}, {24'd0, bus.sum}, {24'd0, es});
      check({tag, "_cout_hold"}, {31'd0, bus.cout}, {31'd0, ec});
    end
  endtask
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                    input logic [7:0] es, input logic ec, input logic eo, input int hold);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.start = 1'b1;
    tick();
    check({tag, "_busy_rise"}, {31'd0, bus.busy}, 1);
    check({tag, "_sum_clr"}, {24'd0, bus.sum}, 0);
    watch(tag, es, ec, eo, hold, 12);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.cin = 1'b0;
    tick();
    tick();
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_sum", {24'd0, bus.sum}, 0);
    check("rst_cout", {31'd0, bus.cout}, 0);
    check_ovf("rst_ovf", 1'b0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, bus.busy}, 0);
    op("basic", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
    op("carry_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op("carry_ffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    op("cin_a55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    op("ign_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 8);
    bus.a = 8'h55;
    bus.b = 8'h55;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    check("mrst_busy", {31'd0, bus.busy}, 0);
    check("mrst_done", {31'd0, bus.done}, 0);
    check("mrst_sum", {24'd0, bus.sum}, 0);
    check("mrst_cout", {31'd0, bus.cout}, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("mrst_no_done", {31'd0, bus.done}, 0);
      check("mrst_no_busy", {31'd0, bus.busy}, 0);
      tick();
    end
    op("after_rst", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0);
    op("ovf_7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    op("ovf_8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    op("ovf_1020", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);
    bus.a = 8'h21;
    bus.b = 8'h10;
    bus.cin = 1'b0;
    bus.start = 1'b1;
    tick();
    watch("b2b_first", 8'h31, 1'b0, 1'b0, 0, 8);
    check("b2b_done1", {31'd0, bus.done}, 1);
    check("b2b_sum1", {24'd0, bus.sum}, 8'h31);
    bus.a = 8'h40;
    bus.b = 8'h02;
    bus.cin = 1'b1;
    bus.start = 1'b1;
    tick();
    check("b2b_busy2", {31'd0, bus.busy}, 1);
    check("b2b_done_low", {31'd0, bus.done}, 0);
    check("b2b_sum_clr", {24'd0, bus.sum}, 0);
    watch("b2b_second", 8'h43, 1'b0, 1'b0, 0, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
